// File: rtl/axi4_pattern_writer.sv
// AXI4 write master that streams a free-running counter pattern as INCR bursts.
// Define AXI4_PATTERN_WRITER_READBACK_EN to add a read-back verify pass after the writes.
module axi4_pattern_writer #(
  parameter logic [0:0]  C_ID        = 1'b0,
  parameter logic [31:0] C_DATA_SEED = 32'h0000_0000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [7:0]  burst_len,
  input  logic [15:0] num_bursts,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [0:0]  M_AXI_AWID,
  output logic [31:0] M_AXI_AWADDR,
  output logic [7:0]  M_AXI_AWLEN,
  output logic [2:0]  M_AXI_AWSIZE,
  output logic [1:0]  M_AXI_AWBURST,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WLAST,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
`ifdef AXI4_PATTERN_WRITER_READBACK_EN
  output logic [0:0]  M_AXI_ARID,
  output logic [31:0] M_AXI_ARADDR,
  output logic [7:0]  M_AXI_ARLEN,
  output logic [2:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [0:0]  M_AXI_RID,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
`endif
  input  logic [0:0]  M_AXI_BID,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned CNT_W  = 16;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
`ifdef AXI4_PATTERN_WRITER_READBACK_EN
    S_AR,
    S_R,
`endif
    S_DONE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [CNT_W-1:0]    nb_q;
  logic [CNT_W-1:0]    burst_idx;
  logic [LEN_W-1:0]    beat;
  logic [DATA_W-1:0]   data_cnt;
  logic [ADDR_W-1:0]   stride;
  logic                last_burst;

  // Byte distance between consecutive bursts: (len+1) beats of 4 bytes.
  assign stride     = ADDR_W'({len_q, 2'b00}) + ADDR_W'(4);
  assign last_burst = (burst_idx + CNT_W'(1)) == nb_q;

  assign M_AXI_AWID    = C_ID;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = len_q;
  assign M_AXI_AWSIZE  = 3'd2;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WDATA   = data_cnt;

`ifdef AXI4_PATTERN_WRITER_READBACK_EN
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] job_seed;
  logic [DATA_W-1:0] rd_exp;

  assign M_AXI_ARID    = C_ID;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_ARSIZE  = 3'd2;
  assign M_AXI_ARBURST = 2'b01;
`endif

  // Job sequencer; all handshake outputs are registered here.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      nb_q          <= '0;
      burst_idx     <= '0;
      beat          <= '0;
      data_cnt      <= C_DATA_SEED;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_WLAST   <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
`ifdef AXI4_PATTERN_WRITER_READBACK_EN
      base_q        <= '0;
      job_seed      <= C_DATA_SEED;
      rd_exp        <= C_DATA_SEED;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q    <= base_addr;
            len_q     <= burst_len;
            nb_q      <= num_bursts;
            burst_idx <= '0;
            error     <= 1'b0;
            busy      <= 1'b1;
`ifdef AXI4_PATTERN_WRITER_READBACK_EN
            base_q    <= base_addr;
            job_seed  <= data_cnt;
`endif
            if (num_bursts == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              M_AXI_AWVALID <= 1'b1;
              state         <= S_AW;
            end
          end
        end
        S_AW: begin
          if (M_AXI_AWREADY) begin
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b1;
            M_AXI_WLAST   <= (len_q == '0);
            beat          <= '0;
            state         <= S_W;
          end
        end
        S_W: begin
          if (M_AXI_WREADY) begin
            data_cnt    <= data_cnt + DATA_W'(1);
            beat        <= beat + LEN_W'(1);
            M_AXI_WLAST <= (beat + LEN_W'(1)) == len_q;
            if (M_AXI_WLAST) begin
              M_AXI_WVALID <= 1'b0;
              M_AXI_WLAST  <= 1'b0;
              M_AXI_BREADY <= 1'b1;
              state        <= S_B;
            end
          end
        end
        S_B: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            if (M_AXI_BRESP != RESP_OKAY || M_AXI_BID != C_ID) error <= 1'b1;
            if (last_burst) begin
`ifdef AXI4_PATTERN_WRITER_READBACK_EN
              addr_q        <= base_q;
              burst_idx     <= '0;
              rd_exp        <= job_seed;
              M_AXI_ARVALID <= 1'b1;
              state         <= S_AR;
`else
              done  <= 1'b1;
              state <= S_DONE;
`endif
            end else begin
              burst_idx     <= burst_idx + CNT_W'(1);
              addr_q        <= addr_q + stride;
              M_AXI_AWVALID <= 1'b1;
              state         <= S_AW;
            end
          end
        end
`ifdef AXI4_PATTERN_WRITER_READBACK_EN
        S_AR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            beat          <= '0;
            state         <= S_R;
          end
        end
        S_R: begin
          if (M_AXI_RVALID) begin
            rd_exp <= rd_exp + DATA_W'(1);
            beat   <= beat + LEN_W'(1);
            if (M_AXI_RDATA != rd_exp || M_AXI_RRESP != RESP_OKAY ||
                M_AXI_RID != C_ID || M_AXI_RLAST != (beat == len_q))
              error <= 1'b1;
            // Burst length is enforced by our own beat count, not by RLAST.
            if (beat == len_q) begin
              M_AXI_RREADY <= 1'b0;
              if (last_burst) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                burst_idx     <= burst_idx + CNT_W'(1);
                addr_q        <= addr_q + stride;
                M_AXI_ARVALID <= 1'b1;
                state         <= S_AR;
              end
            end
          end
        end
`endif
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_pattern_writer.sv
// Scoreboard bench for axi4_pattern_writer: randomized slave, queue-based expected traffic.
`timescale 1ns/1ps
module tb_axi4_pattern_writer;

  localparam logic [0:0]  ID   = 1'b0;
  localparam logic [31:0] SEED = 32'h0000_0000;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [7:0]  burst_len = '0;
  logic [15:0] num_bursts = '0;
  logic        busy, done, error;
  logic [0:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid;
  logic        wready = 1'b0;
  logic [0:0]  bid = ID;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
`ifdef AXI4_PATTERN_WRITER_READBACK_EN
  logic [0:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b1;
  logic [0:0]  rid = ID;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
`endif

  always #5 ACLK = ~ACLK;

  axi4_pattern_writer #(.C_ID(ID), .C_DATA_SEED(SEED)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .base_addr(base_addr),
    .burst_len(burst_len), .num_bursts(num_bursts),
    .busy(busy), .done(done), .error(error),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
`ifdef AXI4_PATTERN_WRITER_READBACK_EN
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
`endif
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [31:0] data; logic last; } w_t;

  aw_t exp_aw[$];
  w_t  exp_w[$];
  logic [31:0] model_cnt = SEED;

  int total = 0;
  int bad = 0;
  int aw_mode = 0, w_mode = 0;
  int w_hs = 0, wlast_cnt = 0, bhs_cnt = 0, b_issued = 0, err_b_at = -1;
  int done_cnt = 0, aw_cycles = 0;
  logic err_at_done = 1'b0;
  logic prev_done = 1'b0;
  logic aw_hold = 1'b0, w_hold = 1'b0;
  logic [31:0] aw_prev_addr = '0, w_prev_data = '0;
  logic [7:0]  aw_prev_len = '0;
  logic        w_prev_last = 1'b0;
`ifdef AXI4_PATTERN_WRITER_READBACK_EN
  aw_t exp_ar[$];
  aw_t ar_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] w_base = '0;
  int w_beat = 0, rhs_cnt = 0;
  logic corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = '0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: burst n sits at base + n*(len+1)*4; data continues from the running counter.
  task automatic expect_job(input logic [31:0] base, input logic [7:0] len, input logic [15:0] nb);
    for (int n = 0; n < int'(nb); n++) begin
      logic [31:0] a;
      a = base + 32'(n) * (32'(len) + 32'd1) * 32'd4;
      exp_aw.push_back('{a, len});
`ifdef AXI4_PATTERN_WRITER_READBACK_EN
      exp_ar.push_back('{a, len});
`endif
      for (int b = 0; b <= int'(len); b++) begin
        exp_w.push_back('{model_cnt, b == int'(len)});
        model_cnt = model_cnt + 32'd1;
      end
    end
  endtask

  task automatic monitor();
    aw_t ea;
    w_t  ew;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        aw_hold = 1'b0; w_hold = 1'b0; prev_done = 1'b0;
        continue;
      end
      if (awvalid) begin
        aw_cycles++;
        if (aw_hold) begin
          check("aw_stable_addr", awaddr, aw_prev_addr);
          check("aw_stable_len", 32'(awlen), 32'(aw_prev_len));
        end
        aw_hold = !awready; aw_prev_addr = awaddr; aw_prev_len = awlen;
        if (awready) begin
          if (exp_aw.size() == 0) check("aw_unexpected", 32'd1, 32'd0);
          else begin
            ea = exp_aw.pop_front();
            check("awaddr", awaddr, ea.addr);
            check("awlen", 32'(awlen), 32'(ea.len));
            check("aw_const", {23'd0, awid, awsize, awburst, 2'b00}, {23'd0, ID, 3'd2, 2'b01, 2'b00});
`ifdef AXI4_PATTERN_WRITER_READBACK_EN
            wa_q.push_back(awaddr);
`endif
          end
        end
      end else begin
        if (aw_hold) check("aw_dropped", 32'(awvalid), 32'd1);
        aw_hold = 1'b0;
      end
      if (wvalid) begin
        if (w_hold) begin
          check("w_stable_data", wdata, w_prev_data);
          check("w_stable_last", 32'(wlast), 32'(w_prev_last));
        end
        w_hold = !wready; w_prev_data = wdata; w_prev_last = wlast;
        if (wready) begin
          w_hs++;
          if (wlast) wlast_cnt++;
          if (exp_w.size() == 0) check("w_unexpected", 32'd1, 32'd0);
          else begin
            ew = exp_w.pop_front();
            check("wdata", wdata, ew.data);
            check("wlast", 32'(wlast), 32'(ew.last));
            check("wstrb", 32'(wstrb), 32'hF);
          end
`ifdef AXI4_PATTERN_WRITER_READBACK_EN
          if (w_beat == 0 && wa_q.size() > 0) w_base = wa_q.pop_front();
          mem[w_base + 32'(w_beat) * 32'd4] = wdata;
          w_beat = wlast ? 0 : w_beat + 1;
`endif
        end
      end else begin
        if (w_hold) check("w_dropped", 32'(wvalid), 32'd1);
        w_hold = 1'b0;
      end
      if (bvalid && bready) bhs_cnt++;
`ifdef AXI4_PATTERN_WRITER_READBACK_EN
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) check("ar_unexpected", 32'd1, 32'd0);
        else begin
          ea = exp_ar.pop_front();
          check("araddr", araddr, ea.addr);
          check("arlen", 32'(arlen), 32'(ea.len));
          ar_q.push_back('{araddr, arlen});
        end
      end
      if (rvalid && rready) rhs_cnt++;
`endif
      if (prev_done) begin
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
      end
      if (done) begin
        done_cnt++;
        err_at_done = error;
        check("busy_in_done", 32'(busy), 32'd1);
      end
      prev_done = done;
    end
  endtask

  task automatic slave();
    int aw_wait = 0;
`ifdef AXI4_PATTERN_WRITER_READBACK_EN
    aw_t cur;
    logic rd_act = 1'b0;
    int r_base = 0;
    int beat;
`endif
    forever begin
      @(posedge ACLK); #1;
      if (ARESET) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; aw_wait = 0;
        continue;
      end
      case (aw_mode)
        0: awready = 1'b1;
        1: awready = 1'($urandom_range(0, 1));
        default: begin
          if (awvalid && aw_wait < 5) begin awready = 1'b0; aw_wait++; end
          else begin awready = awvalid; if (!awvalid) aw_wait = 0; end
        end
      endcase
      case (w_mode)
        0: wready = 1'b1;
        1: wready = 1'($urandom_range(0, 1));
        default: wready = ~wready;
      endcase
      if (bvalid && bhs_cnt == b_issued) bvalid = 1'b0;
      if (!bvalid && b_issued < wlast_cnt && (aw_mode == 0 || $urandom_range(0, 2) != 0)) begin
        bresp = (b_issued == err_b_at) ? 2'b10 : 2'b00;
        bvalid = 1'b1;
        b_issued++;
      end
`ifdef AXI4_PATTERN_WRITER_READBACK_EN
      if (!rd_act && ar_q.size() > 0) begin
        cur = ar_q.pop_front(); rd_act = 1'b1; r_base = rhs_cnt;
      end
      rvalid = 1'b0;
      if (rd_act) begin
        beat = rhs_cnt - r_base;
        if (beat > int'(cur.len)) rd_act = 1'b0;
        else begin
          rvalid = 1'b1;
          rdata = mem[cur.addr + 32'(beat) * 32'd4];
          if (corrupt_en && cur.addr + 32'(beat) * 32'd4 == corrupt_addr) rdata = rdata ^ 32'h0000_0100;
          rlast = (beat == int'(cur.len));
          rresp = 2'b00;
        end
      end
`endif
    end
  endtask

  task automatic run_job(input logic [31:0] base, input logic [7:0] len, input logic [15:0] nb,
                         input logic exp_err, input logic poke);
    int d0;
    d0 = done_cnt;
    expect_job(base, len, nb);
    @(posedge ACLK); #1;
    start = 1'b1; base_addr = base; burst_len = len; num_bursts = nb;
    @(posedge ACLK); #1;
    start = 1'b0; base_addr = $urandom; burst_len = 8'($urandom); num_bursts = 16'($urandom);
    check("awvalid_after_start", 32'(awvalid), 32'(nb != 0));
    check("done_after_start", 32'(done), 32'(nb == 0));
    check("error_cleared_by_start", 32'(error), 32'd0);
    if (poke) begin
      @(posedge ACLK); #1;
      if (busy) begin
        start = 1'b1;
        @(posedge ACLK); #1;
        start = 1'b0;
      end
    end
    for (int c = 0; c < 20000 && done_cnt == d0; c++) @(posedge ACLK);
    check("job_completed", 32'(done_cnt - d0), 32'd1);
    @(posedge ACLK); #1;
    check("error_at_done", 32'(err_at_done), 32'(exp_err));
    check("aw_left", 32'(exp_aw.size()), 32'd0);
    check("w_left", 32'(exp_w.size()), 32'd0);
  endtask

  initial begin
    int a0, w0;
    logic [7:0] rl;
    fork
      monitor();
      slave();
    join_none

    repeat (3) @(posedge ACLK);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
    check("rst_wdata", wdata, SEED);
    ARESET = 1'b0;

    run_job(32'h0000_0100, 8'd7, 16'd1, 1'b0, 1'b0);
    run_job(32'h0000_0200, 8'd3, 16'd3, 1'b0, 1'b0);

    aw_mode = 2; w_mode = 2;
    run_job(32'h0000_0300, 8'd5, 16'd2, 1'b0, 1'b1);

    aw_mode = 1; w_mode = 1;
    err_b_at = bhs_cnt + 1;
    run_job(32'h0000_1000, 8'd3, 16'd3, 1'b1, 1'b0);
    err_b_at = -1;
    repeat (3) @(posedge ACLK);
    #1;
    check("error_sticky", 32'(error), 32'd1);

    a0 = aw_cycles;
    run_job(32'h0000_2000, 8'd4, 16'd0, 1'b0, 1'b0);
    check("no_aw_for_zero_bursts", 32'(aw_cycles - a0), 32'd0);

    aw_mode = 0; w_mode = 0;
    run_job(32'hFFFF_FFF0, 8'd3, 16'd3, 1'b0, 1'b0);
    run_job(32'h0000_0400, 8'd0, 16'd2, 1'b0, 1'b0);

    for (int j = 0; j < 6; j++) begin
      aw_mode = $urandom_range(0, 2);
      w_mode = $urandom_range(0, 2);
      run_job($urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 15)),
              16'($urandom_range(0, 4)), 1'b0, 1'($urandom_range(0, 1)));
    end

    aw_mode = 0; w_mode = 0;
    w0 = w_hs;
    expect_job(32'h0000_4000, 8'd7, 16'd2);
    @(posedge ACLK); #1;
    start = 1'b1; base_addr = 32'h0000_4000; burst_len = 8'd7; num_bursts = 16'd2;
    @(posedge ACLK); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && (w_hs - w0) < 3; c++) begin
      @(posedge ACLK); #1;
    end
    check("reached_w_beat3", 32'(w_hs - w0), 32'd3);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    check("midrst_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
    check("midrst_status", {29'd0, busy, done, error}, 32'd0);
    check("midrst_wdata", wdata, SEED);
    exp_aw.delete();
    exp_w.delete();
`ifdef AXI4_PATTERN_WRITER_READBACK_EN
    exp_ar.delete();
    wa_q.delete();
    w_beat = 0;
`endif
    model_cnt = SEED;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    a0 = aw_cycles;
    repeat (10) @(posedge ACLK);
    #1;
    check("quiet_after_reset", 32'(aw_cycles - a0), 32'd0);
    run_job(32'h0000_0100, 8'd2, 16'd1, 1'b0, 1'b0);

`ifdef AXI4_PATTERN_WRITER_READBACK_EN
    rl = 8'd7;
    corrupt_en = 1'b1;
    corrupt_addr = 32'h0000_5000 + 32'd5 * 32'd4;
    run_job(32'h0000_5000, rl, 16'd2, 1'b1, 1'b0);
    corrupt_en = 1'b0;
    aw_mode = 1; w_mode = 1;
    run_job(32'h0000_6000, rl, 16'd2, 1'b0, 1'b0);
`else
    rl = 8'd0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
